// File: rtl/johnson_dec_pkg.sv
// Shared types and Johnson-code helpers for the phase decoder.
// Codes are zero-extended to JD_MAX_W bits so one function body serves every width N.
package johnson_dec_pkg;

    localparam int JD_MAX_W = 32;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } jd_state_e;

    function automatic int johnson_popcount(input logic [JD_MAX_W-1:0] code, input int n);
        int c;
        c = 0;
        for (int b = 0; b < JD_MAX_W; b++) begin
            if (b < n && ((code >> b) & JD_MAX_W'(1)) != '0) c++;
        end
        return c;
    endfunction

    function automatic logic johnson_msb(input logic [JD_MAX_W-1:0] code, input int n);
        return |(code & (JD_MAX_W'(1) << (n - 1)));
    endfunction

    // Legal codes are a run of ones packed against bit 0 (MSB clear) or against the MSB (MSB set).
    function automatic logic johnson_legal(input logic [JD_MAX_W-1:0] code, input int n);
        logic [JD_MAX_W-1:0] mask;
        logic [JD_MAX_W-1:0] want;
        int                  pop;
        pop  = johnson_popcount(code, n);
        mask = (JD_MAX_W'(1) << n) - JD_MAX_W'(1);
        if (!johnson_msb(code, n))
            want = (JD_MAX_W'(1) << pop) - JD_MAX_W'(1);
        else
            want = mask & ~((JD_MAX_W'(1) << (n - pop)) - JD_MAX_W'(1));
        return (code & mask) == want;
    endfunction

    function automatic int johnson_idx(input logic [JD_MAX_W-1:0] code, input int n);
        int pop;
        pop = johnson_popcount(code, n);
        return johnson_msb(code, n) ? (2 * n - pop) : pop;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson decode: legality flag and binary phase index of one N-bit code.
module johnson_code_decode
    import johnson_dec_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     code,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    logic [JD_MAX_W-1:0] code_ext;

    always_comb begin
        code_ext = JD_MAX_W'(code);
        legal    = johnson_legal(code_ext, N);
        idx      = IDX_W'(johnson_idx(code_ext, N));
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson phase bus monitor: input register, decode, lock FSM, wrap and error counters.
// Optional JOHNSON_DEC_HOLD_EN makes a repeated legal phase neutral instead of a misstep.
module johnson_phase_decoder
    import johnson_dec_pkg::*;
#(
    parameter int  N          = 2,
    parameter int  LOCK_COUNT = 4,
    parameter int  WRAP_W     = 8,
    parameter int  ERR_W      = 8,
    localparam int IDX_W      = $clog2(2 * N)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N-1:0]      I,
    output logic [IDX_W-1:0]  O,
    output logic              valid,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wraps
);

    localparam int                CNT_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(2 * N - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_COUNT - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    logic [N-1:0]     i_q;
    logic             legal;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] prev_idx;
    logic [IDX_W-1:0] next_idx;
    logic             good;
    logic             neutral;
    logic             misstep;
    jd_state_e        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             fault;
    logic             wrap_hit;

    johnson_code_decode #(.N(N), .IDX_W(IDX_W)) u_decode (
        .code  (i_q),
        .legal (legal),
        .idx   (idx)
    );

    // Stage 1: classify the registered code against the last legal phase
    always_comb begin
        next_idx = (prev_idx == LAST_IDX) ? '0 : prev_idx + IDX_W'(1);
        good     = legal && (idx == next_idx);
`ifdef JOHNSON_DEC_HOLD_EN
        neutral  = legal && (idx == prev_idx);
`else
        neutral  = 1'b0;
`endif
        misstep  = legal && !good && !neutral;
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        fault    = 1'b0;
        wrap_hit = 1'b0;
        case (state)
            UNLOCKED: begin
                if (legal) begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                end
            end
            ACQUIRE: begin
                if (!legal) begin
                    state_d = UNLOCKED;
                    cnt_d   = '0;
                end else if (good) begin
                    if (cnt == CNT_LAST) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end else if (misstep) begin
                    cnt_d = '0;
                end
            end
            LOCKED: begin
                if (!legal) begin
                    fault   = 1'b1;
                    state_d = UNLOCKED;
                    cnt_d   = '0;
                end else if (good) begin
                    wrap_hit = (prev_idx == LAST_IDX);
                end else if (misstep) begin
                    fault   = 1'b1;
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = UNLOCKED;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
        O      = prev_idx;
    end

    // Stage 0 capture of the bus and stage 1 state/counter update
    always_ff @(posedge CLK) begin
        if (RESET) begin
            i_q       <= '0;
            state     <= UNLOCKED;
            cnt       <= '0;
            prev_idx  <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            wraps     <= '0;
        end else begin
            i_q   <= I;
            state <= state_d;
            cnt   <= cnt_d;
            valid <= legal;
            err   <= fault;
            if (legal) prev_idx <= idx;
            if (fault) err_count <= sat_inc(err_count);
            if (wrap_hit) wraps <= wraps + WRAP_W'(1);
        end
    end

endmodule
